// File: rtl/echo_indication_serializer.sv
// Purpose : buffer heard(meth,v) indication calls and emit each as a header+payload beat pair.
// Latency : a call accepted at edge N can present its header beat in cycle N+1 (no empty bypass).
// Backpress: pipe_enq__RDY low freezes phase and beat data; heard__RDY depends on registers only.
//
// Ports:
//   CLK, nRST        clock; synchronous active-low reset
//   heard__ENA       method call strobe, only while heard__RDY=1
//   heard_meth       method id (low 16 bits carried in the header)
//   heard_v          payload value (sent as the final beat)
//   heard__RDY       FIFO has room for a call
//   pipe_enq__ENA    a beat transfers this cycle
//   pipe_enq_v       beat data
//   pipe_enq_last    1 on the payload beat
//   pipe_enq__RDY    host pipe can take a beat
//   msg_count        completed messages since reset (wraps)
//   occupancy        FIFO entries held, including the message in flight
module echo_indication_serializer #(
  parameter int          DEPTH      = 4,
  parameter logic [7:0]  HEADER_TAG = 8'hEC
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     heard__ENA,
  input  logic [31:0]              heard_meth,
  input  logic [31:0]              heard_v,
  output logic                     heard__RDY,
  output logic                     pipe_enq__ENA,
  output logic [31:0]              pipe_enq_v,
  output logic                     pipe_enq_last,
  input  logic                     pipe_enq__RDY,
  output logic [31:0]              msg_count,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {
    PH_HDR  = 1'b0,
    PH_BODY = 1'b1
  } phase_t;

  // Entry layout: {meth[15:0], v[31:0]}
  logic [47:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [31:0]   msg_cnt_q;
  phase_t        phase_q;
  phase_t        phase_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [47:0]   head;

  // Upper method-id bits are not carried in the message.
  logic          unused_meth_hi;
  assign unused_meth_hi = ^heard_meth[31:16];

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // A pop in the same cycle does not free a slot for a push while full,
  // which keeps heard__RDY free of any path from the host pipe.
  assign heard__RDY = !full;
  assign push       = heard__ENA && !full;

  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign occupancy  = wr_ptr_q - rd_ptr_q;
  assign msg_count  = msg_cnt_q;

  // Storage has no reset: validity is tracked purely by the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {heard_meth[15:0], heard_v};
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      msg_cnt_q <= '0;
      phase_q   <= PH_HDR;
    end else begin
      phase_q <= phase_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PW'(1);
        msg_cnt_q <= msg_cnt_q + 32'd1;
      end
    end
  end

  // Head entry is read in place; it is popped only once its payload beat leaves,
  // so header and payload of one message can never be split by another.
  always_comb begin
    phase_d       = phase_q;
    pipe_enq__ENA = 1'b0;
    pipe_enq_v    = 32'd0;
    pipe_enq_last = 1'b0;
    pop           = 1'b0;
    if (!empty) begin
      case (phase_q)
        PH_HDR: begin
          pipe_enq_v = {HEADER_TAG, 8'd2, head[47:32]};
          if (pipe_enq__RDY) begin
            pipe_enq__ENA = 1'b1;
            phase_d       = PH_BODY;
          end
        end
        PH_BODY: begin
          pipe_enq_v    = head[31:0];
          pipe_enq_last = 1'b1;
          if (pipe_enq__RDY) begin
            pipe_enq__ENA = 1'b1;
            phase_d       = PH_HDR;
            pop           = 1'b1;
          end
        end
        default: begin
          phase_d = PH_HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_echo_indication_serializer.sv
module tb_echo_indication_serializer;

  logic        CLK;
  logic        nRST;
  logic        heard_ena;
  logic [31:0] heard_meth;
  logic [31:0] heard_v;
  logic        heard_rdy;
  logic        enq_ena;
  logic [31:0] enq_v;
  logic        enq_last;
  logic        enq_rdy;
  logic [31:0] msg_count;
  logic [2:0]  occ;

  int checks   = 0;
  int failures = 0;

  // Captured beats {last, data} and expected beats from the bench model.
  logic [32:0] beats[$];
  logic [32:0] exp_beats[$];

  echo_indication_serializer #(.DEPTH(4), .HEADER_TAG(8'hEC)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .heard__ENA    (heard_ena),
    .heard_meth    (heard_meth),
    .heard_v       (heard_v),
    .heard__RDY    (heard_rdy),
    .pipe_enq__ENA (enq_ena),
    .pipe_enq_v    (enq_v),
    .pipe_enq_last (enq_last),
    .pipe_enq__RDY (enq_rdy),
    .msg_count     (msg_count),
    .occupancy     (occ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Beats transfer at the next posedge; inputs are stable from posedge+1.
  always @(negedge CLK) begin
    if (nRST && enq_ena) beats.push_back({enq_last, enq_v});
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_push(input logic [31:0] m, input logic [31:0] v);
    heard_ena  = 1'b1;
    heard_meth = m;
    heard_v    = v;
    exp_beats.push_back({1'b0, 8'hEC, 8'h02, m[15:0]});
    exp_beats.push_back({1'b1, v});
    tick();
    heard_ena = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && beats.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    nRST = 1'b0; heard_ena = 1'b0; heard_meth = '0; heard_v = '0; enq_rdy = 1'b1;
    tick(); tick();
    nRST = 1'b1;
    @(negedge CLK);
    checks++; if (heard_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy: got %b expected 1", heard_rdy); end
    checks++; if (enq_ena !== 1'b0) begin failures++; $display("FAIL reset_ena: got %b expected 0", enq_ena); end
    checks++; if (msg_count !== 32'd0) begin failures++; $display("FAIL reset_count: got %h expected 0", msg_count); end
    checks++; if (occ !== 3'd0) begin failures++; $display("FAIL reset_occ: got %0d expected 0", occ); end
    tick();
  endtask

  task automatic test_single();
    beats.delete(); exp_beats.delete();
    enq_rdy    = 1'b1;
    heard_ena  = 1'b1; heard_meth = 32'h0001_0005; heard_v = 32'hDEAD_BEEF;
    @(negedge CLK);
    checks++; if (enq_ena !== 1'b0) begin failures++; $display("FAIL single_nobypass: got %b expected 0", enq_ena); end
    tick();
    heard_ena = 1'b0;
    @(negedge CLK);
    checks++; if ({enq_ena, enq_last, enq_v} !== {2'b10, 32'hEC02_0005}) begin failures++; $display("FAIL single_hdr: got ena=%b last=%b v=%h expected ena=1 last=0 v=ec020005", enq_ena, enq_last, enq_v); end
    tick();
    @(negedge CLK);
    checks++; if ({enq_ena, enq_last, enq_v} !== {2'b11, 32'hDEAD_BEEF}) begin failures++; $display("FAIL single_body: got ena=%b last=%b v=%h expected ena=1 last=1 v=deadbeef", enq_ena, enq_last, enq_v); end
    tick();
    checks++; if (msg_count !== 32'd1) begin failures++; $display("FAIL single_count: got %0d expected 1", msg_count); end
    checks++; if (occ !== 3'd0) begin failures++; $display("FAIL single_occ: got %0d expected 0", occ); end
    checks++; if (enq_ena !== 1'b0) begin failures++; $display("FAIL single_idle: got %b expected 0", enq_ena); end
  endtask

  task automatic test_fill();
    beats.delete(); exp_beats.delete();
    enq_rdy = 1'b0;
    for (int i = 0; i < 4; i++) do_push(32'hA5A5_0010 + i, 32'h1000_0000 + i);
    checks++; if (heard_rdy !== 1'b0) begin failures++; $display("FAIL fill_rdy: got %b expected 0", heard_rdy); end
    checks++; if (occ !== 3'd4) begin failures++; $display("FAIL fill_occ: got %0d expected 4", occ); end
    heard_ena = 1'b1; heard_meth = 32'h0000_0BAD; heard_v = 32'hBAD0_BAD0;
    tick();
    heard_ena = 1'b0;
    checks++; if (occ !== 3'd4) begin failures++; $display("FAIL fill_fifth: got occ=%0d expected 4", occ); end
    enq_rdy = 1'b1;
    tick();
    checks++; if (heard_rdy !== 1'b0) begin failures++; $display("FAIL fill_rdy_hdr: got %b expected 0", heard_rdy); end
    tick();
    checks++; if (heard_rdy !== 1'b1) begin failures++; $display("FAIL fill_rdy_pop: got %b expected 1", heard_rdy); end
    checks++; if (occ !== 3'd3) begin failures++; $display("FAIL fill_occ_pop: got %0d expected 3", occ); end
    wait_beats(8, 20);
    tick();
    checks++; if (beats.size() != 8) begin failures++; $display("FAIL fill_beat_count: got %0d expected 8", beats.size()); end
    for (int i = 0; i < 8 && i < beats.size(); i++) begin
      checks++; if (beats[i] !== exp_beats[i]) begin failures++; $display("FAIL fill_beat%0d: got %h expected %h", i, beats[i], exp_beats[i]); end
    end
    checks++; if (msg_count !== 32'd5) begin failures++; $display("FAIL fill_count: got %0d expected 5", msg_count); end
  endtask

  task automatic test_backpressure();
    beats.delete(); exp_beats.delete();
    enq_rdy = 1'b1;
    do_push(32'h0000_0077, 32'hCAFE_F00D);
    tick();
    enq_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if ({enq_ena, enq_last, enq_v} !== {2'b01, 32'hCAFE_F00D}) begin failures++; $display("FAIL bp_hold%0d: got ena=%b last=%b v=%h expected ena=0 last=1 v=cafef00d", i, enq_ena, enq_last, enq_v); end
      tick();
    end
    enq_rdy = 1'b1;
    @(negedge CLK);
    checks++; if ({enq_ena, enq_v} !== {1'b1, 32'hCAFE_F00D}) begin failures++; $display("FAIL bp_resume: got ena=%b v=%h expected ena=1 v=cafef00d", enq_ena, enq_v); end
    tick();
    checks++; if (msg_count !== 32'd6) begin failures++; $display("FAIL bp_count: got %0d expected 6", msg_count); end
    checks++; if (beats.size() != 2 || beats[0] !== 33'h0_EC02_0077) begin failures++; $display("FAIL bp_beats: got n=%0d first=%h expected n=2 first=0ec020077", beats.size(), beats.size() > 0 ? beats[0] : 33'h0); end
  endtask

  task automatic test_simultaneous();
    int sent;
    beats.delete(); exp_beats.delete();
    enq_rdy = 1'b0;
    do_push(32'h0000_0A01, 32'hAAAA_0001);
    do_push(32'h0000_0A02, 32'hAAAA_0002);
    checks++; if (occ !== 3'd2) begin failures++; $display("FAIL sim_occ_pre: got %0d expected 2", occ); end
    enq_rdy = 1'b1;
    tick();
    do_push(32'h0000_0A03, 32'hAAAA_0003);
    checks++; if (occ !== 3'd2) begin failures++; $display("FAIL sim_occ: got %0d expected 2", occ); end
    sent = 0;
    for (int c = 0; c < 400 && sent < 20; c++) begin
      enq_rdy = ($urandom_range(0, 3) != 0);
      if (heard_rdy && $urandom_range(0, 2) == 0) begin
        do_push(32'hFFFF_0100 + sent, 32'h5000_0000 + sent * 3);
        sent++;
      end else begin
        tick();
      end
    end
    enq_rdy = 1'b1;
    wait_beats(46, 200);
    tick();
    checks++; if (beats.size() != 46) begin failures++; $display("FAIL sim_beat_count: got %0d expected 46", beats.size()); end
    for (int i = 0; i < 46 && i < beats.size(); i++) begin
      checks++; if (beats[i] !== exp_beats[i]) begin failures++; $display("FAIL sim_beat%0d: got %h expected %h", i, beats[i], exp_beats[i]); end
    end
  endtask

  task automatic test_reset_mid();
    beats.delete(); exp_beats.delete();
    enq_rdy = 1'b0;
    for (int i = 0; i < 3; i++) do_push(32'h0000_0C00 + i, 32'hC000_0000 + i);
    enq_rdy = 1'b1;
    tick();
    enq_rdy = 1'b0;
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    enq_rdy = 1'b1;
    checks++; if (occ !== 3'd0) begin failures++; $display("FAIL rst_mid_occ: got %0d expected 0", occ); end
    checks++; if (msg_count !== 32'd0) begin failures++; $display("FAIL rst_mid_count: got %0d expected 0", msg_count); end
    checks++; if (enq_ena !== 1'b0) begin failures++; $display("FAIL rst_mid_ena: got %b expected 0", enq_ena); end
    beats.delete(); exp_beats.delete();
    do_push(32'h0000_0D0D, 32'h1234_5678);
    wait_beats(2, 10);
    checks++; if (beats.size() < 2 || beats[0] !== 33'h0_EC02_0D0D || beats[1] !== 33'h1_1234_5678) begin failures++; $display("FAIL rst_mid_next: got n=%0d first=%h expected first=0ec020d0d second=112345678", beats.size(), beats.size() > 0 ? beats[0] : 33'h0); end
    tick();
  endtask

  task automatic test_wrap();
    int sent;
    beats.delete(); exp_beats.delete();
    enq_rdy = 1'b1;
    force dut.msg_cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.msg_cnt_q;
    do_push(32'h0000_0E0E, 32'h0F0F_0F0F);
    wait_beats(2, 10);
    tick();
    checks++; if (msg_count !== 32'd0) begin failures++; $display("FAIL wrap_count: got %h expected 0", msg_count); end
    beats.delete(); exp_beats.delete();
    sent = 0;
    for (int c = 0; c < 200 && sent < 12; c++) begin
      if (heard_rdy) begin
        do_push(32'h7777_0200 + sent, 32'h9000_0000 + sent);
        sent++;
      end else begin
        tick();
      end
    end
    wait_beats(24, 60);
    tick();
    checks++; if (beats.size() != 24) begin failures++; $display("FAIL wrap_beat_count: got %0d expected 24", beats.size()); end
    for (int i = 0; i < 24 && i < beats.size(); i++) begin
      checks++; if (beats[i] !== exp_beats[i]) begin failures++; $display("FAIL wrap_beat%0d: got %h expected %h", i, beats[i], exp_beats[i]); end
    end
    checks++; if (msg_count !== 32'd12) begin failures++; $display("FAIL wrap_count2: got %0d expected 12", msg_count); end
    checks++; if (occ !== 3'd0) begin failures++; $display("FAIL wrap_occ: got %0d expected 0", occ); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
